// File: rtl/wb_mem_slave.sv
// Wishbone B3 slave with an internal word-addressed RAM, classic cycles and out-of-range errors.
// Define WB_MEM_BURST_EN to add linear incrementing bursts (cti=2, bte=0); otherwise every request is classic.
module wb_mem_slave #(
    parameter int unsigned WWIDTH  = 32,
    parameter int unsigned ADDRESS = 25,
    parameter int unsigned DEPTH   = 10,
    parameter bit          HIGHZ   = 1'b0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    input  logic [ADDRESS-1:0]    wb_adr_i,
    input  logic [WWIDTH/8-1:0]   wb_sel_i,
    input  logic [WWIDTH-1:0]     wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [WWIDTH/8-1:0]   wb_sel_o,
    output logic [WWIDTH-1:0]     wb_dat_o
);
    localparam int unsigned NB = WWIDTH / 8;

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERR} state_e;

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [DEPTH-1:0]  addr_q, addr_d;
    logic [WWIDTH-1:0] rdata_q, rdata_d;
    logic [WWIDTH-1:0] mem_q [0:(1<<DEPTH)-1];

    logic req, out_of_range, burst_req, ack, wr_en;

    assign req          = wb_cyc_i & wb_stb_i;
    assign ack          = ack_q & wb_cyc_i & wb_stb_i;
    assign out_of_range = |(wb_adr_i >> DEPTH);
    assign wr_en        = ack & wb_we_i & ~wb_rst_i;

`ifdef WB_MEM_BURST_EN
    assign burst_req = (wb_cti_i == 3'd2) && (wb_bte_i == 2'd0);
`else
    assign burst_req = 1'b0;
    logic unused_burst_ctl;
    assign unused_burst_ctl = ^{wb_cti_i, wb_bte_i};
`endif

    // addr_q is the word of the beat currently offered (the burst pointer in BURST)
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                ack_d  = 1'b0;
                addr_d = wb_adr_i[DEPTH-1:0];
                if (req) begin
                    if (out_of_range) begin
                        state_d = ERR;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = burst_req ? BURST : CLASSIC;
                    end
                end
            end
            CLASSIC: begin
                if (!wb_cyc_i || ack) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
`ifdef WB_MEM_BURST_EN
            BURST: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else if (ack) begin
                    addr_d = addr_q + DEPTH'(1);
                    if (wb_cti_i != 3'd2) begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                    end
                end
            end
`endif
            ERR: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Read data is fetched one cycle ahead from the next beat's word; a write
    // committing to that same word this edge is forwarded byte by byte.
    always_comb begin
        rdata_d = mem_q[addr_d];
        if (wr_en && (addr_d == addr_q)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wb_sel_i[i]) rdata_d[8*i +: 8] = wb_dat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wb_sel_i[i]) mem_q[addr_q][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    assign wb_ack_o = ack;
    assign wb_err_o = (state_q == ERR);
    assign wb_rty_o = 1'b0;

    generate
        if (HIGHZ) begin : g_highz
            assign wb_dat_o = ack ? rdata_q : 'z;
            assign wb_sel_o = ack ? (wb_we_i ? '0 : '1) : 'z;
        end else begin : g_drive
            assign wb_dat_o = ack ? rdata_q : '0;
            assign wb_sel_o = (ack & ~wb_we_i) ? '1 : '0;
        end
    endgenerate

endmodule
